// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and pipeline depth helper for the
// carry-chained adder/subtractor datapath.
package alu_pkg;

    typedef enum logic [0:0] {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    // Depth of a carry-chained pipeline; never below one stage.
    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
        if ((width / chunk) < 32'd1) begin
            return 32'd1;
        end else begin
            return width / chunk;
        end
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple slice used by each pipe_add_sub stage.
module add_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);

    // One-bit-wider add so the slice carry falls out of the top bit
    always_comb begin
        {c_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
    end

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits per stage, valid/ready with full backpressure.
// Optional ovf/zero flags are built only when PIPE_ADD_SUB_FLAGS_EN is defined.
module pipe_add_sub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             cout;
        logic             ovf;
        logic             zero;
    } result_t;

    // Operands travel raw; op2 is inverted per chunk from the stored op so sub is consumed everywhere
    logic [WIDTH-1:0] a_r       [STAGES];
    logic [WIDTH-1:0] b_r       [STAGES];
    logic [WIDTH-1:0] res_r     [STAGES];
    logic             c_r       [STAGES];
    logic             v_r       [STAGES];
    alu_op_e          op_r      [STAGES];
    logic [WIDTH-1:0] a_nxt_s   [STAGES];
    logic [WIDTH-1:0] b_nxt_s   [STAGES];
    logic [WIDTH-1:0] res_nxt_s [STAGES];
    logic             c_nxt_s   [STAGES];
    alu_op_e          op_nxt_s  [STAGES];
    logic             stall_s;
    result_t          result_s;

    assign stall_s  = v_r[STAGES-1] & ~out_ready;
    assign in_ready = rst_n & ~stall_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src_s;
        logic [WIDTH-1:0] b_src_s;
        logic [WIDTH-1:0] res_src_s;
        logic             c_src_s;
        alu_op_e          op_src_s;
        logic [CHUNK-1:0] b_eff_s;
        logic [CHUNK-1:0] sum_s;
        logic             c_out_s;

        if (k == 0) begin : g_first
            assign a_src_s   = op1;
            assign b_src_s   = op2;
            assign res_src_s = '0;
            assign c_src_s   = cin ^ sub;
            assign op_src_s  = sub ? ALU_SUB : ALU_ADD;
        end else begin : g_next
            assign a_src_s   = a_r[k-1];
            assign b_src_s   = b_r[k-1];
            assign res_src_s = res_r[k-1];
            assign c_src_s   = c_r[k-1];
            assign op_src_s  = op_r[k-1];
        end

        assign b_eff_s = b_src_s[k*CHUNK +: CHUNK] ^ {CHUNK{op_src_s == ALU_SUB}};

        add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
            .a     (a_src_s[k*CHUNK +: CHUNK]),
            .b     (b_eff_s),
            .c_in  (c_src_s),
            .sum   (sum_s),
            .c_out (c_out_s)
        );

        // Chunks above the current one are still zero, so OR-ing in the new chunk is enough
        assign res_nxt_s[k] = res_src_s | (WIDTH'(sum_s) << (k * CHUNK));
        assign a_nxt_s[k]   = a_src_s;
        assign b_nxt_s[k]   = b_src_s;
        assign c_nxt_s[k]   = c_out_s;
        assign op_nxt_s[k]  = op_src_s;
    end

    // Stage registers: cleared on reset, frozen as a whole while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                res_r[k] <= '0;
                c_r[k]   <= 1'b0;
                v_r[k]   <= 1'b0;
                op_r[k]  <= ALU_ADD;
            end
        end else if (!stall_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= a_nxt_s[k];
                b_r[k]   <= b_nxt_s[k];
                res_r[k] <= res_nxt_s[k];
                c_r[k]   <= c_nxt_s[k];
                op_r[k]  <= op_nxt_s[k];
            end
            v_r[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_r[k] <= v_r[k-1];
            end
        end
    end

`ifdef PIPE_ADD_SUB_FLAGS_EN
    logic ovf_r;
    logic zero_r;
    logic b_msb_s;
    logic a_msb_s;
    logic ovf_nxt_s;
    logic zero_nxt_s;

    assign a_msb_s    = a_nxt_s[STAGES-1][WIDTH-1];
    assign b_msb_s    = b_nxt_s[STAGES-1][WIDTH-1] ^ (op_nxt_s[STAGES-1] == ALU_SUB);
    assign ovf_nxt_s  = (a_msb_s == b_msb_s) && (res_nxt_s[STAGES-1][WIDTH-1] != a_msb_s);
    assign zero_nxt_s = (res_nxt_s[STAGES-1] == '0);

    // Flags are formed alongside the final chunk and move with the last stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (!stall_s) begin
            ovf_r  <= ovf_nxt_s;
            zero_r <= zero_nxt_s;
        end
    end

    assign result_s = '{out: res_r[STAGES-1], cout: c_r[STAGES-1], ovf: ovf_r, zero: zero_r};
`else
    assign result_s = '{out: res_r[STAGES-1], cout: c_r[STAGES-1], ovf: 1'b0, zero: 1'b0};
`endif

    assign out_valid = v_r[STAGES-1];
    assign out       = result_s.out;
    assign cout      = result_s.cout;
    assign ovf       = result_s.ovf;
    assign zero      = result_s.zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: directed corner cases, stall, reset, random stream
// against an arithmetic reference model. Flag expectations follow PIPE_ADD_SUB_FLAGS_EN.
module tb_pipe_add_sub;

    localparam int W      = 8;
    localparam int C      = 4;
    localparam int STAGES = W / C;
`ifdef PIPE_ADD_SUB_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] out;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc_cyc;
        int           stall0;
        bit           seen;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    logic         zero;

    int     checks    = 0;
    int     errors    = 0;
    int     cyc       = 0;
    int     stall_cnt = 0;
    bit     prev_stall = 1'b0;
    logic [W:0] prev_res;
    exp_t   exp_q[$];

    pipe_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c);
        exp_t   e;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint lc   = longint'(c);
        longint half = longint'(1) << (W - 1);
        longint full = longint'(1) << W;
        longint sa   = (ua >= half) ? ua - full : ua;
        longint sb   = (ub >= half) ? ub - full : ub;
        longint r;
        longint sr;
        r      = s ? (ua - ub - lc) : (ua + ub + lc);
        sr     = s ? (sa - sb - lc) : (sa + sb + lc);
        e.out  = r[W-1:0];
        e.cout = s ? (ua >= ub + lc) : (r >= full);
        e.ovf  = FLAGS_EN && ((sr > half - 1) || (sr < -half));
        e.zero = FLAGS_EN && (e.out == '0);
        e.acc_cyc = 0;
        e.stall0  = 0;
        e.seen    = 1'b0;
        return e;
    endfunction

    task automatic tick(output bit acc);
        exp_t e;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_out", 64'({cout, out}), 64'(prev_res));
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q[0];
                chk("out", 64'(out), 64'(e.out));
                chk("cout", 64'(cout), 64'(e.cout));
                chk("ovf", 64'(ovf), 64'(e.ovf));
                chk("zero", 64'(zero), 64'(e.zero));
                if (!e.seen) begin
                    chk("latency", 64'(cyc - e.acc_cyc), 64'(STAGES + stall_cnt - e.stall0));
                    exp_q[0].seen = 1'b1;
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = {cout, out};
        if (prev_stall) stall_cnt++;
        acc = in_valid && in_ready;
        if (acc) begin
            e = model(op1, op2, sub, cin);
            e.acc_cyc = cyc;
            e.stall0  = stall_cnt;
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        bit acc = 1'b0;
        op1 = a; op2 = b; sub = s; cin = c; in_valid = 1'b1;
        for (int g = 0; g < 50 && !acc; g++) tick(acc);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int g = 0; g < 100 && exp_q.size() != 0; g++) tick(acc);
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        for (int g = 0; g < 3; g++) tick(acc);
    endtask

    initial begin
        bit acc;
        int i;
        int guard;
        logic [W-1:0] sa [6];
        logic [W-1:0] sb [6];

        rst_n = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed corner cases
        send(8'h0F, 8'h0F, 1'b0, 1'b0);
        drain();
        send(8'hF0, 8'h0F, 1'b0, 1'b1);
        send(8'h05, 8'h07, 1'b1, 1'b0);
        send(8'h7F, 8'h01, 1'b0, 1'b0);
        send(8'hFF, 8'hFF, 1'b0, 1'b1);
        send(8'h5A, 8'h5A, 1'b1, 1'b0);
        send(8'h80, 8'h01, 1'b1, 1'b1);
        drain();

        // Back-to-back stream with a 3-cycle consumer stall in the middle
        for (int k = 0; k < 6; k++) begin
            sa[k] = W'($urandom);
            sb[k] = W'($urandom);
        end
        i = 0;
        guard = 0;
        while (i < 6 && guard < 40) begin
            out_ready = !(guard >= 3 && guard < 6);
            in_valid = 1'b1; op1 = sa[i]; op2 = sb[i]; sub = i[0]; cin = i[1];
            tick(acc);
            if (acc) i++;
            guard++;
        end
        chk("stream_sent", 64'(i), 64'd6);
        drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out", 64'(out), 64'd0);
        chk("midrst_cout", 64'(cout), 64'd0);
        chk("midrst_ovf", 64'(ovf), 64'd0);
        chk("midrst_zero", 64'(zero), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) tick(acc);
        send(8'h01, 8'h01, 1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure
        for (int g = 0; g < 400; g++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op1 = W'($urandom);
            op2 = ($urandom_range(0, 7) == 0) ? op1 : W'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
            tick(acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
